// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, default byte width and index-width helper for the uart_tx arbiter
package uart_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} arb_state_t;
  localparam int DATA_W = 8;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational rotating-priority picker, first valid index at or above rr_ptr
module uart_rr_pick import uart_pkg::*; #(
  parameter int NUM_REQ = 4,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IW-1:0]      rr_ptr,
  output logic [IW-1:0]      pick_idx,
  output logic               pick_vld
);
  logic [IW-1:0] idx;
  // Scan offsets from farthest to nearest so the nearest valid index wins
  always_comb begin
    pick_idx = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[idx]) pick_idx = idx;
    end
  end
  assign pick_vld = |req_valid;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx between NUM_REQ producers; optional watchdog via UART_ARB_WATCHDOG_EN
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = uart_pkg::DATA_W,
  parameter int WD_CYCLES = 16,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [IW-1:0]             grant_id,
  output logic                      active,
  output logic                      wd_err
);
  arb_state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, rr_q, rr_d, pick_idx;
  logic [DATA_W-1:0] data_q, data_d;
  logic pick_vld, wd_hit, take, done;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_valid(req_valid),
    .rr_ptr(rr_q),
    .pick_idx(pick_idx),
    .pick_vld(pick_vld)
  );

`ifdef UART_ARB_WATCHDOG_EN
  localparam int CW = $clog2(WD_CYCLES + 1);
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic wd_err_q;
  // Counter holds clocks elapsed since tx_start while waiting for busy to rise
  always_comb wd_cnt_d = (state_q == LAUNCH) ? CW'(1) : (state_q == WAIT_BUSY) ? wd_cnt_q + 1'b1 : wd_cnt_q;
  assign wd_hit = (state_q == WAIT_BUSY) && !tx_busy && (wd_cnt_q == CW'(WD_CYCLES - 1));
  // Watchdog counter and abort pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_hit;
    end
  assign wd_err = wd_err_q;
`else
  assign wd_hit = 1'b0;
  assign wd_err = 1'b0;
`endif

  assign take = (state_q == IDLE) && pick_vld;
  assign done = (state_q == WAIT_DONE) && !tx_busy;

  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;

  // Next-state: one launch cycle, then wait for busy to rise and fall (or watchdog abort)
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = pick_vld ? LAUNCH : IDLE;
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: state_d = tx_busy ? WAIT_DONE : wd_hit ? IDLE : WAIT_BUSY;
      default:   state_d = tx_busy ? WAIT_DONE : IDLE;
    endcase
  end

  // Grant/data capture on arbitration; pointer moves past the grantee when its frame ends
  always_comb begin
    grant_d = take ? pick_idx : grant_q;
    data_d = take ? req_data[pick_idx*DATA_W +: DATA_W] : data_q;
    rr_d = (done || wd_hit) ? ((grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1) : rr_q;
  end

  // Grant, data and round-robin pointer registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      grant_q <= '0;
      data_q <= '0;
      rr_q <= '0;
    end else begin
      grant_q <= grant_d;
      data_q <= data_d;
      rr_q <= rr_d;
    end

  // Outputs decoded from the state register only
  always_comb begin
    tx_start = (state_q == LAUNCH);
    req_ready = tx_start ? (NUM_REQ'(1) << grant_q) : '0;
    active = (state_q != IDLE);
  end

  assign tx_data = data_q;
  assign grant_id = grant_q;
endmodule
